// File: rtl/pipeline_pkg.sv
// Shared definitions for the two-stage RV32I pipeline control logic:
// writeback-select encodings, hazard FSM states and the x0 register index.
package pipeline_pkg;

    // MW-stage writeback source select
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    // Hazard controller sequencing states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    // Architectural zero register; never a forwarding source
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding compare: selects the MW writeback value for an Execute
// operand when MW writes the same non-zero register.
module hazard_fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       reg_wr_i,
    output logic       fwd_a_o,
    output logic       fwd_b_o
);

    logic rd_live;

    // Source/destination match against a live, non-x0 destination
    always_comb begin
        rd_live = reg_wr_i && (rd_i != REG_ZERO);
        fwd_a_o = rd_live && (rd_i == rs1_i);
        fwd_b_o = rd_live && (rd_i == rs2_i);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the two-stage (F/E -> M/W) RV32I pipeline.
// Drives operand forwarding, load-use stall with timeout, and branch flush.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating 32-bit
// stall_cnt / flush_cnt / fwd_cnt performance counter outputs.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_E,
    input  logic [4:0]  rs2_E,
    input  logic [4:0]  rd_MW,
    input  logic        reg_wrMW,
    input  logic [1:0]  wb_selMW,
    input  logic        br_taken,
    input  logic        dmem_ready,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic        stall,
    output logic        flush,
    output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] fwd_cnt
`endif
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [7:0] FL_LAST = 8'(FLUSH_CYCLES - 1);

    hz_state_t  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_pend;
    logic       stall_d, flush_d, err_d;
    logic       fwd_a_raw, fwd_b_raw;

    hazard_fwd_unit u_fwd (
        .rs1_i    (rs1_E),
        .rs2_i    (rs2_E),
        .rd_i     (rd_MW),
        .reg_wr_i (reg_wrMW),
        .fwd_a_o  (fwd_a_raw),
        .fwd_b_o  (fwd_b_raw)
    );

    // Next-state and control decode; memory wait has priority over branch
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        err_d     = 1'b0;
        load_pend = reg_wrMW && (wb_selMW == WB_MEM) && !dmem_ready;
        case (state_q)
            RUN: begin
                if (load_pend) begin
                    stall_d = 1'b1;
                    state_d = MEM_WAIT;
                    cnt_d   = 8'd1;
                end else if (br_taken) begin
                    flush_d = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = 8'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    stall_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            FLUSH: begin
                // br_taken here belongs to a squashed slot and is ignored
                flush_d = 1'b1;
                if (cnt_q == FL_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted
    always_comb begin
        fwd_a   = rst && fwd_a_raw;
        fwd_b   = rst && fwd_b_raw;
        stall   = rst && stall_d;
        flush   = rst && flush_d;
        mem_err = rst && err_d;
    end

    // State and wait/flush counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, fwd_cnt_q;

    // Saturating event counters for stall, flush and forwarding cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= sat_inc32(stall_cnt_q, stall);
            flush_cnt_q <= sat_inc32(flush_cnt_q, flush);
            fwd_cnt_q   <= sat_inc32(fwd_cnt_q, fwd_a || fwd_b);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share the
// stimulus: inst0 (FLUSH_CYCLES=2, MEM_TIMEOUT=4) and inst1 (1, 16).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_E, rs2_E, rd_MW;
    logic       reg_wrMW;
    logic [1:0] wb_selMW;
    logic       br_taken, dmem_ready;

    logic fwd_a_o [2];
    logic fwd_b_o [2];
    logic stall_o [2];
    logic flush_o [2];
    logic err_o   [2];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] scnt_o [2];
    logic [31:0] fcnt_o [2];
    logic [31:0] wcnt_o [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut0 (
        .clk(clk), .rst(rst), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_MW(rd_MW),
        .reg_wrMW(reg_wrMW), .wb_selMW(wb_selMW), .br_taken(br_taken),
        .dmem_ready(dmem_ready), .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]),
        .stall(stall_o[0]), .flush(flush_o[0]), .mem_err(err_o[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(scnt_o[0]), .flush_cnt(fcnt_o[0]), .fwd_cnt(wcnt_o[0])
`endif
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_MW(rd_MW),
        .reg_wrMW(reg_wrMW), .wb_selMW(wb_selMW), .br_taken(br_taken),
        .dmem_ready(dmem_ready), .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]),
        .stall(stall_o[1]), .flush(flush_o[1]), .mem_err(err_o[1])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(scnt_o[1]), .flush_cnt(fcnt_o[1]), .fwd_cnt(wcnt_o[1])
`endif
    );

    // Reference model: counters of stalled cycles and remaining bubbles
    int          m_fc  [2] = '{2, 1};
    int          m_to  [2] = '{4, 16};
    int          wait_len   [2];
    int          flush_left [2];
    int unsigned p_stall [2];
    int unsigned p_flush [2];
    int unsigned p_fwd   [2];
    bit          e_s [2], e_f [2], e_e [2], e_a [2], e_b [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval(input int k);
        bit lp;
        lp = reg_wrMW && (wb_selMW == 2'd1) && !dmem_ready;
        e_s[k] = 0; e_f[k] = 0; e_e[k] = 0;
        e_a[k] = rst && reg_wrMW && (rd_MW != 0) && (rd_MW == rs1_E);
        e_b[k] = rst && reg_wrMW && (rd_MW != 0) && (rd_MW == rs2_E);
        if (rst) begin
            if (flush_left[k] > 0) e_f[k] = 1;
            else if (wait_len[k] > 0) begin
                if (!dmem_ready) begin
                    if (wait_len[k] == m_to[k] - 1) e_e[k] = 1;
                    else e_s[k] = 1;
                end
            end
            else if (lp) e_s[k] = 1;
            else if (br_taken) e_f[k] = 1;
        end
    endtask

    task automatic model_advance(input int k);
        bit lp;
        lp = reg_wrMW && (wb_selMW == 2'd1) && !dmem_ready;
        if (!rst) begin
            wait_len[k] = 0; flush_left[k] = 0;
            p_stall[k] = 0; p_flush[k] = 0; p_fwd[k] = 0;
        end else begin
            p_stall[k] += e_s[k];
            p_flush[k] += e_f[k];
            p_fwd[k]   += (e_a[k] || e_b[k]);
            if (flush_left[k] > 0) flush_left[k]--;
            else if (wait_len[k] > 0) begin
                if (dmem_ready || wait_len[k] == m_to[k] - 1) wait_len[k] = 0;
                else wait_len[k]++;
            end
            else if (lp) wait_len[k] = 1;
            else if (br_taken) flush_left[k] = m_fc[k] - 1;
        end
    endtask

    // Compare every output with the model, then take one clock edge
    task automatic step(input string tag);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            check_eq($sformatf("%s/i%0d/fwd_a", tag, k), fwd_a_o[k], e_a[k]);
            check_eq($sformatf("%s/i%0d/fwd_b", tag, k), fwd_b_o[k], e_b[k]);
            check_eq($sformatf("%s/i%0d/stall", tag, k), stall_o[k], e_s[k]);
            check_eq($sformatf("%s/i%0d/flush", tag, k), flush_o[k], e_f[k]);
            check_eq($sformatf("%s/i%0d/mem_err", tag, k), err_o[k], e_e[k]);
`ifdef HAZARD_PERF_CNT_EN
            check_eq($sformatf("%s/i%0d/stall_cnt", tag, k), scnt_o[k], p_stall[k]);
            check_eq($sformatf("%s/i%0d/flush_cnt", tag, k), fcnt_o[k], p_flush[k]);
            check_eq($sformatf("%s/i%0d/fwd_cnt", tag, k), wcnt_o[k], p_fwd[k]);
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_advance(k);
        @(negedge clk);
    endtask

    task automatic drive(input bit wr, input bit [1:0] wb, input bit br, input bit rdy);
        reg_wrMW = wr; wb_selMW = wb; br_taken = br; dmem_ready = rdy;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            wait_len[k] = 0; flush_left[k] = 0;
            p_stall[k] = 0; p_flush[k] = 0; p_fwd[k] = 0;
        end
        rst = 1'b0; rs1_E = 5'd5; rs2_E = 5'd5; rd_MW = 5'd5;
        drive(1, 2'd1, 1, 0);
        @(negedge clk);
        #1;
        check_eq("rst_fwd_a", fwd_a_o[0], 0);
        check_eq("rst_stall", stall_o[0], 0);
        check_eq("rst_flush", flush_o[1], 0);
        step("reset");
        step("reset");

        // Forwarding
        rst = 1'b1;
        drive(1, 2'd0, 0, 1);
        #1;
        check_eq("fwd_rd5_a", fwd_a_o[0], 1);
        check_eq("fwd_rd5_b", fwd_b_o[1], 1);
        step("fwd5");
        rd_MW = 5'd0;
        #1;
        check_eq("fwd_rd0_a", fwd_a_o[0], 0);
        check_eq("fwd_rd0_b", fwd_b_o[0], 0);
        step("fwd0");

        // Load stall: ready low three cycles then high
        rd_MW = 5'd7;
        drive(1, 2'd1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("load_stall_on", stall_o[0], 1);
            step("load");
        end
        dmem_ready = 1'b1;
        #1;
        check_eq("load_stall_off", stall_o[0], 0);
        step("load_rdy");
        drive(0, 2'd0, 0, 1);
        step("load_run");

        // Branch: two bubbles, second br_taken ignored
        drive(0, 2'd0, 1, 1);
        step("br1");
        #1;
        check_eq("br_flush2", flush_o[0], 1);
        step("br2");
        br_taken = 1'b0;
        #1;
        check_eq("br_ignored", flush_o[0], 0);
        step("br3");

        // Timeout on inst0
        drive(1, 2'd1, 0, 0);
        for (int i = 0; i < 3; i++) step("to_wait");
        #1;
        check_eq("to_err", err_o[0], 1);
        check_eq("to_stall", stall_o[0], 0);
        step("to_err");
        drive(0, 2'd0, 0, 1);
        #1;
        check_eq("to_err_once", err_o[0], 0);
        step("to_after");

        // Simultaneous load and branch
        drive(1, 2'd1, 1, 0);
        #1;
        check_eq("sim_stall", stall_o[0], 1);
        check_eq("sim_noflush", flush_o[0], 0);
        step("sim1");
        dmem_ready = 1'b1;
        step("sim_rdy");
        drive(0, 2'd0, 1, 1);
        #1;
        check_eq("sim_flush", flush_o[0], 1);
        step("sim_br");
        br_taken = 1'b0;
        step("sim_idle");
        step("sim_idle");

        // Reset in the middle of a load wait
        drive(1, 2'd1, 0, 0);
        step("rw1");
        step("rw2");
        rst = 1'b0;
        #1;
        check_eq("rw_stall", stall_o[0], 0);
        step("rw_rst");
        rst = 1'b1;
        drive(0, 2'd0, 0, 0);
        #1;
        check_eq("rw_noerr", err_o[0], 0);
        check_eq("rw_nostall", stall_o[0], 0);
`ifdef HAZARD_PERF_CNT_EN
        check_eq("rw_scnt", scnt_o[0], 0);
`endif
        step("rw_run");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned rp;
            rp = (i / 500) % 2 == 0 ? 4 : 16;
            rst        = ($urandom_range(0, 99) != 0);
            rs1_E      = 5'($urandom_range(0, 3));
            rs2_E      = 5'($urandom_range(0, 3));
            rd_MW      = 5'($urandom_range(0, 3));
            reg_wrMW   = 1'($urandom_range(0, 1));
            wb_selMW   = 2'($urandom_range(0, 3));
            br_taken   = ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, rp - 1) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
